matmul_nxn_seq: RTL and testbench
=================================

Name: matmul_nxn_seq

Overview:
- Parametrised successor to the fixed 4x4 matrix multiplier: computes C = A x B, or C = C + A x B, for NxN matrices with configurable element and result widths.
- Uses N parallel MACs, one per output column. Each row of C takes N cycles; a full product takes N*N cycles.
- Adds accumulate mode, signed operation, saturation with an overflow flag, and a busy/done handshake.
- Sits behind the same start/done control as the existing test benches. Matrices use flattened buses.

Parameters:
- N, 4, matrix dimension (>=2).
- DW, 8, operand element width in bits.
- CW, 16, result element width in bits (>= 2*DW).
- SIGNED, 0, 1 = operands and results are two's complement; 0 = unsigned.
- SAT, 1, 1 = saturate results to the CW range; 0 = wrap modulo 2^CW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- acc_mode  in  1  sampled with start. 1 = add the product to the current C contents.
- a_flat  in  N*N*DW  matrix A; element [i][j] at bits [(i*N+j)*DW +: DW].
- b_flat  in  N*N*DW  matrix B; same packing as a_flat.
- c_flat  out  N*N*CW  result matrix C; element [i][j] at bits [(i*N+j)*CW +: CW].
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when C is complete.
- ovf  out  1  sticky: set if any element saturated or wrapped since the last accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - c_flat, busy, done, ovf, row/k counters and accumulators all = 0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE with start=1 at edge E0:
  - Latch a_flat, b_flat and acc_mode into internal registers. Later input changes have no effect.
  - Clear ovf; set i=0, k=0; busy=1 from E0; state goes to RUN.
- start while RUN or DONE is ignored. No re-latch, no restart.
- RUN, each edge, for every column j: acc[j] += A[i][k]*B[k][j], computed at full precision.
  - Internal width is max(CW, 2*DW+clog2(N))+1. Signedness follows SIGNED.
- RUN, edge with k==N-1:
  - For each j: r = acc[j] + product, plus C_old[i][j] if acc_mode is latched.
  - C_old is interpreted per SIGNED at full precision.
  - r is then reduced to CW bits:
    - SAT=1: clamp to [0, 2^CW-1] unsigned, or [-2^(CW-1), 2^(CW-1)-1] signed.
    - SAT=0: truncate to the low CW bits.
  - If r was outside the CW range, set ovf=1.
  - Write row i of c_flat; clear acc; k=0; i=i+1.
- Rows of c_flat update progressively during RUN; C is valid only from done onward.
- Edge E(N*N), the last MAC (i==N-1, k==N-1): state goes to DONE, done=1 and busy=0 after this edge.
  - Start-to-done latency is N*N cycles (16 for N=4).
- DONE: next edge sets done=0 and state=IDLE. A new start is accepted from the following edge.
- c_flat and ovf hold their values until the next accepted start or reset.
- Accumulate mode with acc_mode=0 overwrites C. Accumulate mode after reset adds to zeros.

Test Plan:
- Product timing, N=4, unsigned: A=I, B=2I, acc_mode=0, pulse start → busy high for 16 cycles, done pulses exactly 16 edges after start. C diagonal=2, off-diagonal=0, ovf=0.
- Saturation (SAT=1 vs SAT=0), N=4, CW=16: all elements 255 in A and B; raw sum 260100 →
  - SAT=1: every C element = 65535, ovf=1.
  - SAT=0: every C element = 63492 (260100 mod 65536), ovf=1.
- Accumulate: run A=I, B=2I with acc_mode=0, then again with acc_mode=1 → diagonal=4, off-diagonal=0, ovf=0.
- Start during busy: extra start pulse at cycle 5 of RUN, with a_flat changed → done still at cycle 16, exactly one done pulse, result uses the original A.
- Reset mid-operation: rst_n low at cycle 8 → c_flat=0, busy=0, done=0 immediately. No done pulse later; a fresh start after release completes normally.
- Signed instance, N=2, SIGNED=1, CW=16: A=[[-1,2],[3,-4]], B=I → C = 0xFFFF, 0x0002, 0x0003, 0xFFFC; done 4 cycles after start; ovf=0.

Source files
------------

// File: rtl/matmul_nxn_seq.sv
// Sequential NxN matrix multiplier: C = A x B or C = C + A x B, one row of C per N cycles.
// N column MACs run in parallel; results are saturated or wrapped to CW bits with a sticky ovf.
module matmul_nxn_seq #(
    parameter int unsigned N      = 4,
    parameter int unsigned DW     = 8,
    parameter int unsigned CW     = 16,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned SAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                acc_mode,
    input  logic [N*N*DW-1:0]   a_flat,
    input  logic [N*N*DW-1:0]   b_flat,
    output logic [N*N*CW-1:0]   c_flat,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int unsigned PW = 2 * DW + $clog2(N);
    localparam int unsigned IW = ((CW > PW) ? CW : PW) + 1;
    localparam int unsigned XW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q;
    logic [N*N*DW-1:0]   a_q, b_q;
    logic                acc_mode_q;
    logic [XW-1:0]       i_q, k_q;
    logic [IW-1:0]       acc_q [N];
    logic [CW-1:0]       c_q [N][N];

    logic [DW-1:0]       a_m [N][N];
    logic [DW-1:0]       b_m [N][N];
    logic [IW-1:0]       prod [N];
    logic [IW-1:0]       mac [N];
    logic [IW-1:0]       res [N];
    logic [CW-1:0]       red [N];
    logic [N-1:0]        row_ovf;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign a_m[gi][gj] = a_q[(gi*N+gj)*DW +: DW];
            assign b_m[gi][gj] = b_q[(gi*N+gj)*DW +: DW];
            assign c_flat[(gi*N+gj)*CW +: CW] = c_q[gi][gj];
        end
    end

    function automatic logic [IW-1:0] ext_d(input logic [DW-1:0] x);
        logic s;
        s = (SIGNED != 0) && x[DW-1];
        return {{(IW-DW){s}}, x};
    endfunction

    function automatic logic [IW-1:0] ext_c(input logic [CW-1:0] x);
        logic s;
        s = (SIGNED != 0) && x[CW-1];
        return {{(IW-CW){s}}, x};
    endfunction

    always_comb begin
        row_ovf = '0;
        for (int unsigned j = 0; j < N; j++) begin
            prod[j] = ext_d(a_m[i_q][k_q]) * ext_d(b_m[k_q][j]);
            mac[j]  = acc_q[j] + prod[j];
            res[j]  = mac[j] + (acc_mode_q ? ext_c(c_q[i_q][j]) : '0);
            // Out of range when the bits above the CW result are not a pure extension.
            if (SIGNED != 0) begin
                row_ovf[j] = !((&res[j][IW-1:CW-1]) || !(|res[j][IW-1:CW-1]));
            end else begin
                row_ovf[j] = |res[j][IW-1:CW];
            end
            red[j] = res[j][CW-1:0];
            if (SAT != 0 && row_ovf[j]) begin
                if (SIGNED != 0) begin
                    red[j] = {res[j][IW-1], {(CW-1){~res[j][IW-1]}}};
                end else begin
                    red[j] = '1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            acc_mode_q <= 1'b0;
            i_q        <= '0;
            k_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            for (int unsigned j = 0; j < N; j++) begin
                acc_q[j] <= '0;
                for (int unsigned r = 0; r < N; r++) begin
                    c_q[r][j] <= '0;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q        <= a_flat;
                        b_q        <= b_flat;
                        acc_mode_q <= acc_mode;
                        ovf        <= 1'b0;
                        i_q        <= '0;
                        k_q        <= '0;
                        busy       <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (k_q == XW'(N - 1)) begin
                        for (int unsigned j = 0; j < N; j++) begin
                            c_q[i_q][j] <= red[j];
                            acc_q[j]    <= '0;
                        end
                        if (|row_ovf) begin
                            ovf <= 1'b1;
                        end
                        k_q <= '0;
                        if (i_q == XW'(N - 1)) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            i_q <= i_q + XW'(1);
                        end
                    end else begin
                        for (int unsigned j = 0; j < N; j++) begin
                            acc_q[j] <= mac[j];
                        end
                        k_q <= k_q + XW'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_nxn_seq.sv
// Directed bench for matmul_nxn_seq: two unsigned N=4 instances (SAT=1 / SAT=0)
// sharing stimulus, and one signed N=2 instance.
module tb_matmul_nxn_seq;

    logic         clk;
    logic         rst_n;
    logic         start, acc_mode;
    logic [127:0] a_flat, b_flat;
    logic [255:0] c0, c1;
    logic         busy0, done0, ovf0, busy1, done1, ovf1;

    logic         start2;
    logic         acc2;
    logic [31:0]  a2, b2;
    logic [63:0]  c2;
    logic         busy2, done2, ovf2;

    int checks;
    int errors;

    matmul_nxn_seq #(.N(4), .DW(8), .CW(16), .SIGNED(0), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c0),
        .busy(busy0), .done(done0), .ovf(ovf0)
    );

    matmul_nxn_seq #(.N(4), .DW(8), .CW(16), .SIGNED(0), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c1),
        .busy(busy1), .done(done1), .ovf(ovf1)
    );

    matmul_nxn_seq #(.N(2), .DW(8), .CW(16), .SIGNED(1), .SAT(1)) dut_sgn (
        .clk(clk), .rst_n(rst_n), .start(start2), .acc_mode(acc2),
        .a_flat(a2), .b_flat(b2), .c_flat(c2),
        .busy(busy2), .done(done2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ident(input logic [7:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[(i*4+i)*8 +: 8] = s;
        return r;
    endfunction

    function automatic logic [255:0] diag(input logic [15:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[(i*4+i)*16 +: 16] = v;
        return r;
    endfunction

    // Pulse start for one cycle; returns at the falling edge after the accepting edge.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done0 && lat < 40);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; acc_mode = 1'b0; a_flat = '0; b_flat = '0;
        start2 = 1'b0; acc2 = 1'b0; a2 = '0; b2 = '0;
        #12;
        checks++;
        if (c0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: c=%h busy=%b done=%b ovf=%b, required all zero",
                     c0, busy0, done0, ovf0);
        end
        checks++;
        if (c2 !== '0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_signed: c=%h busy=%b, required zero", c2, busy2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_product();
        int bad;
        a_flat = ident(8'd1); b_flat = ident(8'd2); acc_mode = 1'b0;
        kick();
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL product_busy_start: busy=%b, required 1", busy0);
        end
        bad = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL product_busy_window: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL product_done_at_16: done=%b busy=%b, required done=1 busy=0",
                     done0, busy0);
        end
        checks++;
        if (c0 !== diag(16'd2) || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL product_result: c=%h ovf=%b, required %h ovf=0",
                     c0, ovf0, diag(16'd2));
        end
        checks++;
        if (c1 !== diag(16'd2)) begin
            errors++;
            $display("FAIL product_result_wrap: c=%h, required %h", c1, diag(16'd2));
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL product_done_pulse: done=%b, required 0", done0);
        end
    endtask

    task automatic test_accumulate();
        int lat;
        acc_mode = 1'b1;
        kick();
        acc_mode = 1'b0;
        wait_done(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL accumulate_latency: %0d, required 16", lat);
        end
        checks++;
        if (c0 !== diag(16'd4) || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL accumulate_result: c=%h ovf=%b, required %h ovf=0",
                     c0, ovf0, diag(16'd4));
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int lat;
        a_flat = {16{8'hFF}}; b_flat = {16{8'hFF}}; acc_mode = 1'b0;
        kick();
        wait_done(lat);
        checks++;
        if (c0 !== {16{16'hFFFF}} || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL saturation_sat: c=%h ovf=%b, required all ffff ovf=1", c0, ovf0);
        end
        checks++;
        if (c1 !== {16{16'hF804}} || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL saturation_wrap: c=%h ovf=%b, required all f804 ovf=1", c1, ovf1);
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int pulses, first;
        a_flat = ident(8'd1); b_flat = ident(8'd2); acc_mode = 1'b0;
        kick();
        repeat (5) @(negedge clk);
        a_flat = {16{8'hFF}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; first = 0;
        for (int cyc = 7; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                pulses++;
                if (first == 0) first = cyc;
            end
        end
        checks++;
        if (first !== 16 || pulses !== 1) begin
            errors++;
            $display("FAIL start_busy_timing: first done %0d, pulses %0d, required 16 and 1",
                     first, pulses);
        end
        checks++;
        if (c0 !== diag(16'd2) || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_result: c=%h ovf=%b, required %h ovf=0",
                     c0, ovf0, diag(16'd2));
        end
    endtask

    task automatic test_reset_mid();
        int pulses, lat;
        a_flat = ident(8'd1); b_flat = ident(8'd3); acc_mode = 1'b0;
        kick();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (c0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: c=%h busy=%b done=%b, required all zero",
                     c0, busy0, done0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: %0d active cycles, required 0", pulses);
        end
        kick();
        wait_done(lat);
        checks++;
        if (lat !== 16 || c0 !== diag(16'd3)) begin
            errors++;
            $display("FAIL reset_mid_restart: lat=%0d c=%h, required 16 and %h",
                     lat, c0, diag(16'd3));
        end
        @(negedge clk);
    endtask

    task automatic test_signed();
        int lat;
        a2 = {8'hFC, 8'h03, 8'h02, 8'hFF};
        b2 = {8'h01, 8'h00, 8'h00, 8'h01};
        acc2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done2 && lat < 20);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL signed_latency: %0d, required 4", lat);
        end
        checks++;
        if (c2 !== {16'hFFFC, 16'h0003, 16'h0002, 16'hFFFF} || ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL signed_result: c=%h ovf=%b, required fffc00030002ffff ovf=0",
                     c2, ovf2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_product();
        test_accumulate();
        test_saturation();
        test_start_busy();
        test_reset_mid();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
